bcd_display_scanner: RTL and testbench
======================================

BCD_DISPLAY_SCANNER -- requirements
Module: bcd_display_scanner

Interface
REQ-001 Parameter: PRESCALE, default 4, clk cycles per digit slot (legal range 1..65535).
REQ-002 Port: clk  input  1  single clock, all state updates on rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-low reset; 0 clears all state immediately, independent of clk.
REQ-004 Port: load  input  1  when 1 at a rising edge, digits_in is captured into the shadow register.
REQ-005 Port: digits_in  input  16  four BCD nibbles; [3:0]=digit0 (units, e.g. decade_counter count), [15:12]=digit3.
REQ-006 Port: blank_lz  input  1  leading-zero blanking enable.
REQ-007 Port: an  output  4  active-low digit enables, one-hot-low; an[i]=0 selects digit i.
REQ-008 Port: seg  output  7  active-low segments, seg[0]=a ... seg[6]=g.

Function
REQ-009 Shadow register (16 bit) SHALL load digits_in on any edge with load=1 and hold otherwise; display SHALL use only the shadow register.
REQ-010 Prescaler SHALL count 0..PRESCALE-1 and wrap to 0; tick SHALL be asserted in the cycle it holds PRESCALE-1 (every cycle when PRESCALE=1).
REQ-011 Scan index (2 bit) SHALL advance by 1 on each tick edge, wrapping 3->0; full scan period = 4*PRESCALE cycles.
REQ-012 an and seg SHALL be registered, reflecting the scan index and shadow contents of the previous cycle (1-cycle latency).
REQ-013 an SHALL drive exactly one bit low (bit = scan index) at all times outside reset.
REQ-014 seg decode, active-low gfedcba: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-015 Nibbles 10..15 (invalid BCD) SHALL display dash: seg=0111111.
REQ-016 With blank_lz=1: digit3 blanked if 0; digit2 blanked if digits 3,2 both 0; digit1 blanked if digits 3,2,1 all 0; digit0 never blanked.
REQ-017 Blanked digit SHALL drive seg=1111111 while its an bit stays low; invalid nibbles SHALL never be treated as zero for blanking.
REQ-018 Simultaneous load and tick on the same edge SHALL both take effect; the next output update uses the new index and new shadow value.
REQ-019 load mid-scan SHALL NOT reset or stall the prescaler or scan index.
REQ-020 blank_lz SHALL be sampled every cycle (no capture) and takes effect on the next output update.

Reset
REQ-021 On reset=0: prescaler=0, scan index=0, shadow=16'h0000, an=1111, seg=1111111, asynchronously, within the same cycle.
REQ-022 Reset asserted mid-scan SHALL abort the scan with no partial update; reset release is synchronous to the next rising edge.
REQ-023 First rising edge after release SHALL produce an=1110, seg=1000000 (digit0 = 0).

Verification (PRESCALE=4)
REQ-024 Reset pulse low during digit2 slot -> an=1111, seg=1111111 before the next clk edge; after release, first edge -> an=1110, seg=1000000.
REQ-025 load=1 with digits_in=16'h1234, then load=0 -> slots cycle an=1110/seg=0011001, 1101/0110000, 1011/0100100, 0111/1111001, each lasting 4 cycles, repeating every 16 cycles.
REQ-026 digits_in=16'h9A05 -> digit2 slot shows seg=0111111 (dash), digit3 shows 0010000, digit0 shows 0010010.
REQ-027 blank_lz=1, digits_in=16'h0050 -> digits 3,2 seg=1111111, digit1=0010010, digit0=1000000; digits_in=16'h0000 -> only digit0 lit (1000000).
REQ-028 load and tick on the same edge with digits_in changing 16'h0001->16'h0002 -> next slot shows the new value; scan timing unchanged across the load.
REQ-029 decade_counter count driving digits_in[3:0] with load held 1 -> digit0 slot follows 0..9 and wraps 9->0, never showing a dash.

Source files
------------

// File: rtl/bcd_display_scanner.sv
// Multiplexed four-digit BCD display driver: a shadow register feeds a scanned,
// registered seven-segment/anode output with optional leading-zero blanking.
module bcd_display_scanner #(
    parameter int unsigned PRESCALE = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [15:0] digits_in,
    input  logic        blank_lz,
    output logic [3:0]  an,
    output logic [6:0]  seg
);

    localparam int unsigned CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    logic [CW-1:0] pre_cnt;
    logic          tick;
    logic [1:0]    scan_idx;
    logic [15:0]   shadow;

    logic [3:0]    cur_nibble;
    logic [3:0]    blank_digit;
    logic [3:0]    next_an;
    logic [6:0]    next_seg;

    // Active-low gfedcba; anything outside 0..9 shows a dash.
    function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = SEG_DASH;
        endcase
        return s;
    endfunction

    assign tick = (pre_cnt == LAST);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of block order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pre_cnt  <= '0;
            scan_idx <= 2'd0;
        end else begin
            if (tick) begin
                pre_cnt  <= '0;
                scan_idx <= scan_idx + 2'd1;
            end else begin
                pre_cnt  <= pre_cnt + CW'(1);
            end
        end
    end

    // Load is independent of the scan timing so a mid-scan update never stalls it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shadow <= 16'h0000;
        end else if (load) begin
            shadow <= digits_in;
        end
    end

    // Only a genuine 0 nibble counts as a leading zero; invalid codes stop the run.
    assign blank_digit = {4{blank_lz}} & {
        (shadow[15:12] == 4'd0),
        (shadow[15:12] == 4'd0) && (shadow[11:8] == 4'd0),
        (shadow[15:12] == 4'd0) && (shadow[11:8] == 4'd0) && (shadow[7:4] == 4'd0),
        1'b0
    };

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        cur_nibble = 4'd0;
        next_an    = 4'b1111;
        next_seg   = SEG_BLANK;
        cur_nibble = shadow[{scan_idx, 2'b00} +: 4];
        next_an    = ~(4'b0001 << scan_idx);
        next_seg   = blank_digit[scan_idx] ? SEG_BLANK : bcd_to_seg(cur_nibble);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            an  <= 4'b1111;
            seg <= SEG_BLANK;
        end else begin
            an  <= next_an;
            seg <= next_seg;
        end
    end

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Directed bench for bcd_display_scanner (PRESCALE=4): scan order, decode,
// dash, blanking, load/tick collision, decade-counter feed and async reset.
module tb_bcd_display_scanner;

    localparam int unsigned PRESCALE = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        load = 1'b0;
    logic [15:0] digits_in = 16'h0000;
    logic        blank_lz = 1'b0;
    logic [3:0]  an;
    logic [6:0]  seg;

    int checks = 0;
    int failures = 0;
    int n = 0;

    localparam logic [6:0] S0    = 7'b1000000;
    localparam logic [6:0] S1    = 7'b1111001;
    localparam logic [6:0] S2    = 7'b0100100;
    localparam logic [6:0] S3    = 7'b0110000;
    localparam logic [6:0] S4    = 7'b0011001;
    localparam logic [6:0] S5    = 7'b0010010;
    localparam logic [6:0] S9    = 7'b0010000;
    localparam logic [6:0] DASH  = 7'b0111111;
    localparam logic [6:0] BLANK = 7'b1111111;

    bcd_display_scanner #(.PRESCALE(PRESCALE)) dut (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .digits_in (digits_in),
        .blank_lz  (blank_lz),
        .an        (an),
        .seg       (seg)
    );

    always #5 clk = ~clk;

    initial begin
        #50000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0: return 7'b1000000;
            4'd1: return 7'b1111001;
            4'd2: return 7'b0100100;
            4'd3: return 7'b0110000;
            4'd4: return 7'b0011001;
            4'd5: return 7'b0010010;
            4'd6: return 7'b0000010;
            4'd7: return 7'b1111000;
            4'd8: return 7'b0000000;
            4'd9: return 7'b0010000;
            default: return 7'b0111111;
        endcase
    endfunction

    function automatic logic [3:0] an_of(input int s);
        case (s)
            0: return 4'b1110;
            1: return 4'b1101;
            2: return 4'b1011;
            default: return 4'b0111;
        endcase
    endfunction

    // Output slot visible after the n-th rising edge since reset release.
    function automatic int slot_of(input int e);
        return ((e - 1) / PRESCALE) % 4;
    endfunction

    task automatic check(input string tag, input logic [10:0] obs, input logic [10:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b (n=%0d)", tag, obs, exp, n);
        end
    endtask

    task automatic step();
        @(posedge clk);
        n++;
        @(negedge clk);
    endtask

    task automatic check_span(input string tag, input logic [6:0] s0, input logic [6:0] s1,
                              input logic [6:0] s2, input logic [6:0] s3, input int cycles);
        logic [6:0] exp;
        for (int i = 0; i < cycles; i++) begin
            step();
            case (slot_of(n))
                0: exp = s0;
                1: exp = s1;
                2: exp = s2;
                default: exp = s3;
            endcase
            check(tag, {an, seg}, {an_of(slot_of(n)), exp});
        end
    endtask

    initial begin
        logic [3:0] dc;
        logic [3:0] last;
        logic [6:0] exp_seg;

        // Asynchronous reset with no clock edge involved.
        #2 reset = 1'b0;
        #1 check("reset_async", {an, seg}, {4'b1111, BLANK});
        @(negedge clk);
        @(negedge clk);
        check("reset_hold", {an, seg}, {4'b1111, BLANK});

        reset = 1'b1;
        n = 0;
        step();
        check("first_edge", {an, seg}, {4'b1110, S0});

        // 1234 loaded mid-slot; scan order and 16-cycle repetition.
        load = 1'b1;
        digits_in = 16'h1234;
        step();
        load = 1'b0;
        check_span("scan_1234", S4, S3, S2, S1, 18);

        // Invalid nibble shows a dash.
        load = 1'b1;
        digits_in = 16'h9A05;
        step();
        load = 1'b0;
        check_span("dash_9A05", S5, S0, DASH, S9, 15);

        // Leading-zero blanking.
        blank_lz = 1'b1;
        load = 1'b1;
        digits_in = 16'h0050;
        step();
        load = 1'b0;
        check_span("blank_0050", S0, S5, BLANK, BLANK, 16);

        load = 1'b1;
        digits_in = 16'h0000;
        step();
        load = 1'b0;
        check_span("blank_0000", S0, BLANK, BLANK, BLANK, 16);

        load = 1'b1;
        digits_in = 16'h0A00;
        step();
        load = 1'b0;
        check_span("blank_0A00", S0, S0, DASH, BLANK, 16);

        blank_lz = 1'b0;
        check_span("noblank_0A00", S0, S0, DASH, S0, 16);

        // Load coinciding with a tick edge.
        load = 1'b1;
        digits_in = 16'h0001;
        step();
        load = 1'b0;
        check_span("pre_collide", S1, S0, S0, S0, 12);
        while (n < 127) step();
        load = 1'b1;
        digits_in = 16'h0002;
        step();
        load = 1'b0;
        check("collide_edge", {an, seg}, {4'b0111, S0});
        check_span("post_collide", S2, S0, S0, S0, 5);

        // Decade counter driving digit0 with load held high.
        last = 4'd2;
        dc = 4'd0;
        load = 1'b1;
        for (int i = 0; i < 64; i++) begin
            digits_in = {12'h000, dc};
            step();
            exp_seg = (slot_of(n) == 0) ? seg_of(last) : S0;
            check("decade", {an, seg}, {an_of(slot_of(n)), exp_seg});
            last = dc;
            dc = (dc == 4'd9) ? 4'd0 : dc + 4'd1;
        end
        load = 1'b0;

        // Reset pulse during the digit2 slot.
        while (slot_of(n) != 2) step();
        #2 reset = 1'b0;
        #1 check("reset_mid_scan", {an, seg}, {4'b1111, BLANK});
        @(negedge clk);
        check("reset_mid_hold", {an, seg}, {4'b1111, BLANK});
        reset = 1'b1;
        n = 0;
        step();
        check("release_edge", {an, seg}, {4'b1110, S0});
        check_span("after_reset", S0, S0, S0, S0, 7);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
